// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: UART TX state encodings and frame constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

    localparam logic        FrameStart   = 1'b0;
    localparam logic        FrameStop    = 1'b1;
    localparam int unsigned DataBits     = 8;
    localparam int unsigned DefaultDataW = 8;

endpackage

// File: rtl/reg3_fifo.sv
// Synchronous FIFO with a count register; reusable for other CPU output ports.
module reg3_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4,
    parameter int unsigned CntW  = $clog2(Depth) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // A push while full is still taken when a pop frees the slot on the same edge.
    always_comb begin
        do_push  = push_i && (!full_o || pop_i);
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/reg3_uart_tx.sv
// Watches the CPU REG3 output, queues each change and sends it as a UART 8N1 frame.
module reg3_uart_tx
    import cpu_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned DATA_W       = DefaultDataW
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
    input  logic [DATA_W-1:0] i_REG,
    input  logic              i_EN,
    output logic              o_TX,
    output logic              o_BUSY,
    output logic              o_FULL,
    output logic              o_OVF
);
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);

    tx_state_e             state_q, state_d;
    logic [BaudW-1:0]      baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [DataBits-1:0]   shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic [DATA_W-1:0]     prev_q, prev_d;
    logic                  prev_vld_q, prev_vld_d;
    logic                  ovf_q, ovf_d;

    logic                  push;
    logic                  pop;
    logic                  bit_end;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DataBits-1:0]   fifo_rdata;
    logic [CntW-1:0]       fifo_count;

    reg3_fifo #(
        .Width (DataBits),
        .Depth (FIFO_DEPTH),
        .CntW  (CntW)
    ) u_fifo (
        .clk_i   (i_CLK),
        .rst_ni  (i_RST_N),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (DataBits'(i_REG)),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        push       = i_EN && (!prev_vld_q || (i_REG != prev_q));
        prev_d     = i_EN ? i_REG : prev_q;
        prev_vld_d = prev_vld_q | i_EN;
        ovf_d      = ovf_q | (push && fifo_full && !pop);
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= FrameStop;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        bit_end = (baud_q == BaudMax);
        if (state_q != StIdle) begin
            baud_d = bit_end ? '0 : baud_q + BaudW'(1);
        end
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                // Chain straight into the next start bit when more bytes are waiting.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        bit_d   = '0;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level is decided from the next state so o_TX comes straight off a flop.
    always_comb begin
        tx_d = FrameStop;
        unique case (state_d)
            StStart: tx_d = FrameStart;
            StData:  tx_d = shift_d[0];
            default: tx_d = FrameStop;
        endcase
    end

    assign o_TX   = tx_q;
    assign o_BUSY = (state_q != StIdle);
    assign o_FULL = fifo_full;
    assign o_OVF  = ovf_q;

    count_in_range: assert property (@(posedge i_CLK) disable iff (!i_RST_N)
        fifo_count <= CntW'(FIFO_DEPTH));

endmodule

// File: tb/tb_reg3_uart_tx.sv
// Bench for reg3_uart_tx: frame-level model, per-cycle compare and a UART receiver.
module tb_reg3_uart_tx;
    localparam int C  = 4;
    localparam int D  = 4;
    localparam int FL = 10 * C;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [7:0] reg_in = 8'h00;
    logic       en     = 1'b0;
    logic       tx, busy, full, ovf;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 0;

    always #5 clk = ~clk;

    reg3_uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D),
        .DATA_W       (8)
    ) dut (
        .i_CLK   (clk),
        .i_RST_N (rst_n),
        .i_REG   (reg_in),
        .i_EN    (en),
        .o_TX    (tx),
        .o_BUSY  (busy),
        .o_FULL  (full),
        .o_OVF   (ovf)
    );

    // Model: a byte queue plus the active frame as (byte, cycle index into the frame).
    logic [7:0] mq[$];
    bit         m_act  = 0;
    int         m_idx  = 0;
    logic [7:0] m_cur  = 8'h00;
    logic [7:0] m_prev = 8'h00;
    bit         m_vld  = 0;
    bit         m_ovf  = 0;

    initial begin : model
        bit do_push, do_pop;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_act = 0;
                m_idx = 0;
                m_vld = 0;
                m_prev = 8'h00;
                m_ovf = 0;
            end else begin
                do_push = en && (!m_vld || reg_in != m_prev);
                if (en) begin
                    m_prev = reg_in;
                    m_vld  = 1;
                end
                do_pop = (mq.size() > 0) && (!m_act || m_idx == FL - 1);
                if (do_pop) begin
                    m_cur = mq.pop_front();
                    m_idx = 0;
                    m_act = 1;
                end else if (m_act) begin
                    m_idx++;
                    if (m_idx == FL) m_act = 0;
                end
                if (do_push) begin
                    if (mq.size() < D) mq.push_back(reg_in);
                    else m_ovf = 1;
                end
            end
        end
    end

    function automatic logic model_tx();
        int k;
        if (!m_act) return 1'b1;
        k = m_idx / C;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_cur[k-1];
    endfunction

    initial begin : compare
        logic e_tx, e_busy, e_full, e_ovf;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                e_tx   = model_tx();
                e_busy = m_act;
                e_full = (mq.size() == D);
                e_ovf  = m_ovf;
                n_vec++;
                if (tx !== e_tx || busy !== e_busy || full !== e_full || ovf !== e_ovf) begin
                    n_err++;
                    $display("FAIL cycle_compare t=%0t: got tx/busy/full/ovf=%b%b%b%b expected %b%b%b%b",
                             $time, tx, busy, full, ovf, e_tx, e_busy, e_full, e_ovf);
                end
            end
        end
    end

    // Receiver samples mid-bit; frames hit by reset or with a bad start/stop are dropped.
    logic [7:0] rx_log[$];
    int         rx_cnt  = 0;
    logic [7:0] rx_last = 8'hEE;

    initial begin : monitor
        logic       last_tx;
        logic [7:0] b;
        bit         ok;
        int         k;
        last_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0 && last_tx === 1'b1) begin
                ok = 1;
                b  = 8'h00;
                for (int c = 1; c <= 9 * C + C / 2; c++) begin
                    @(negedge clk);
                    if (!rst_n) ok = 0;
                    if (c % C == C / 2) begin
                        k = c / C;
                        if (k == 0) begin
                            if (tx !== 1'b0) ok = 0;
                        end else if (k < 9) begin
                            b[k-1] = tx;
                        end else if (tx !== 1'b1) begin
                            ok = 0;
                        end
                    end
                end
                if (ok) begin
                    rx_log.push_back(b);
                    rx_cnt++;
                    rx_last = b;
                end
            end
            last_tx = tx;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] burst [6];
        int         bcnt;
        burst = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

        // 1. Reset values
        cycles(3);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        cmp_en = 1;

        // 2. First enabled sample is always sent, then nothing while held
        #1 rst_n = 1; en = 1; reg_in = 8'h00;
        cycles(90);
        chk("first_cnt", rx_cnt, 1);
        chk("first_byte", rx_last, 8'h00);
        chk("first_idle", busy, 0);

        // 3. Single change: line falls after the second edge, busy 40 cycles
        #1 reg_in = 8'hA5;
        cycles(1);
        chk("lat_edge_k", tx, 1);
        cycles(1);
        chk("lat_start_tx", tx, 0);
        chk("lat_start_busy", busy, 1);
        bcnt = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        chk("a5_busy_len", bcnt, 40);
        chk("a5_cnt", rx_cnt, 2);
        chk("a5_byte", rx_last, 8'hA5);

        // 4. Burst of six changes: one popped, four queued, one dropped
        #1 reg_in = burst[0];
        bcnt = 0;
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (i == 4) chk("burst_full_k4", full, 1);
            if (i == 5) begin
                chk("burst_full_k5", full, 1);
                chk("burst_ovf", ovf, 1);
            end
            #1;
            if (i < 5) reg_in = burst[i+1];
        end
        chk("burst_busy_len", bcnt, 200);
        chk("burst_cnt", rx_cnt, 7);
        if (rx_log.size() == 7) begin
            for (int j = 0; j < 5; j++) chk($sformatf("burst_byte%0d", j), rx_log[j+2], burst[j]);
        end
        chk("burst_ovf_sticky", ovf, 1);

        // 5. Reset during data bit 3 aborts the frame immediately
        reg_in = 8'hC3;
        cycles(18);
        chk("c3_bit3_low", tx, 0);
        #1 rst_n = 0; en = 0;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_full", full, 0);
        cycles(3);
        #1 rst_n = 1;
        bcnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        chk("abort_no_frame", bcnt, 0);
        chk("abort_cnt", rx_cnt, 7);

        // 6. Enable gating
        #1 reg_in = 8'h11;
        cycles(3);
        #1 reg_in = 8'h22;
        cycles(5);
        chk("gated_busy", busy, 0);
        #1 en = 1;
        cycles(70);
        chk("gated_cnt", rx_cnt, 8);
        chk("gated_byte", rx_last, 8'h22);
        chk("gated_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
